adder_timing_counter: RTL and testbench

- Measurement sequencer directly downstream of the instrumented adder.
- Repeatedly launches the adder carry chain, captures the chain's raw asynchronous output, and counts wb_clk_i cycles until the output arrives.
- Accumulates 2^LOG_RUNS runs and presents the average, plus done/timeout status, to the logic-analyser readback.

---
 rtl/adder_timer_pkg.sv | 18 +
 rtl/sync_2ff.sv | 23 ++
 rtl/adder_timing_counter.sv | 162 ++++++++++++++++
 tb/tb_adder_timing_counter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_timer_pkg.sv
// Shared types and defaults for the adder carry-chain timing counter.
package adder_timer_pkg;

    localparam int unsigned SYNC_STAGES  = 2;
    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned LOG_RUNS_DEF = 3;
    localparam int unsigned TIMEOUT_DEF  = 1000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        ACCUM  = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit flop-chain synchroniser for the asynchronous chain output.
module sync_2ff
    import adder_timer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/adder_timing_counter.sv
// Launches the adder carry chain, times its arrival over 2^LOG_RUNS runs and reports the average.
// Optional min/max per-run cycle outputs are enabled by defining ADDER_TIMER_MINMAX_EN.
module adder_timing_counter
    import adder_timer_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned LOG_RUNS = LOG_RUNS_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    input  logic                active,
    input  logic                start,
    input  logic                chain_in,
    output logic                launch,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [CNT_W-1:0]    result,
`ifdef ADDER_TIMER_MINMAX_EN
    output logic [CNT_W-1:0]    min_cycles,
    output logic [CNT_W-1:0]    max_cycles,
`endif
    output logic [LOG_RUNS:0]   runs_done
);

    localparam int unsigned ACC_W = CNT_W + LOG_RUNS;
    localparam int unsigned RUNS  = 1 << LOG_RUNS;
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [LOG_RUNS:0] RUNS_FULL = (LOG_RUNS+1)'(RUNS);

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [ACC_W-1:0]    acc, acc_next;
    logic [LOG_RUNS:0]   runs_next;
    logic                launch_next, timeout_next, busy_next, done_next;
    logic                chain_s;
`ifdef ADDER_TIMER_MINMAX_EN
    logic [CNT_W-1:0]    min_next, max_next;
`endif

    sync_2ff u_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n),
        .d     (chain_in),
        .q     (chain_s)
    );

    // Next-state and datapath; active low overrides every state.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        acc_next     = acc;
        runs_next    = runs_done;
        launch_next  = launch;
        timeout_next = timeout;
`ifdef ADDER_TIMER_MINMAX_EN
        min_next     = min_cycles;
        max_next     = max_cycles;
`endif
        if (!active) begin
            state_next  = IDLE;
            launch_next = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    launch_next = 1'b0;
                    if (start) begin
                        state_next   = ARM;
                        cnt_next     = '0;
                        acc_next     = '0;
                        runs_next    = '0;
                        timeout_next = 1'b0;
`ifdef ADDER_TIMER_MINMAX_EN
                        min_next     = '1;
                        max_next     = '0;
`endif
                    end
                end
                ARM: begin
                    launch_next = 1'b0;
                    if (!chain_s) begin
                        state_next = LAUNCH;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LIMIT) begin
                        state_next   = DONE;
                        timeout_next = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                LAUNCH: begin
                    state_next  = WAIT;
                    launch_next = 1'b1;
                    cnt_next    = '0;
                end
                WAIT: begin
                    if (chain_s) begin
                        state_next = ACCUM;
                    end else if (cnt == CNT_LIMIT) begin
                        state_next   = DONE;
                        timeout_next = 1'b1;
                        launch_next  = 1'b0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                ACCUM: begin
                    acc_next    = acc + ACC_W'(cnt);
                    runs_next   = runs_done + (LOG_RUNS+1)'(1);
                    launch_next = 1'b0;
                    cnt_next    = '0;
`ifdef ADDER_TIMER_MINMAX_EN
                    if (cnt < min_cycles) min_next = cnt;
                    if (cnt > max_cycles) max_next = cnt;
`endif
                    state_next  = (runs_next == RUNS_FULL) ? DONE : ARM;
                end
                default: begin
                    state_next  = IDLE;
                    launch_next = 1'b0;
                end
            endcase
        end
        busy_next = state_next inside {ARM, LAUNCH, WAIT, ACCUM};
        done_next = (state_next == DONE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            runs_done  <= '0;
            launch     <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef ADDER_TIMER_MINMAX_EN
            min_cycles <= '0;
            max_cycles <= '0;
`endif
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            acc        <= acc_next;
            runs_done  <= runs_next;
            launch     <= launch_next;
            timeout    <= timeout_next;
            busy       <= busy_next;
            done       <= done_next;
`ifdef ADDER_TIMER_MINMAX_EN
            min_cycles <= min_next;
            max_cycles <= max_next;
`endif
        end
    end

    // Average is the accumulator with the run-count bits dropped.
    assign result = acc[ACC_W-1:LOG_RUNS];

endmodule

// File: tb/tb_adder_timing_counter.sv
// Bench for adder_timing_counter: emulated carry chain with per-run delay, table plus random measurements.
module tb_adder_timing_counter;

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned LOG_RUNS = 3;
    localparam int unsigned TIMEOUT  = 20;
    localparam int RUNS     = 8;
    localparam int M_DELAY  = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_STUCK1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic active = 1'b0;
    logic start = 1'b0;
    logic chain_in;
    logic launch, busy, done, timeout;
    logic [CNT_W-1:0]  result;
    logic [LOG_RUNS:0] runs_done;
`ifdef ADDER_TIMER_MINMAX_EN
    logic [CNT_W-1:0]  min_cycles, max_cycles;
`endif

    int mode = M_DELAY;
    int cur_delay = 0;
    int run_idx = 0;
    int rises = 0;
    int run_delay[RUNS] = '{default: 0};
    logic [15:0] lhist = '0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int mode;
        int da;
        int db;
        int e_res;
        int e_runs;
        int e_to;
        int e_rises;
        int e_min;
        int e_max;
    } vec_t;

    vec_t vecs[6];

    adder_timing_counter #(
        .CNT_W    (CNT_W),
        .LOG_RUNS (LOG_RUNS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .active     (active),
        .start      (start),
        .chain_in   (chain_in),
        .launch     (launch),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .result     (result),
`ifdef ADDER_TIMER_MINMAX_EN
        .min_cycles (min_cycles),
        .max_cycles (max_cycles),
`endif
        .runs_done  (runs_done)
    );

    always #5 clk = ~clk;

    // Carry chain model: launch delayed by a per-run number of registered cycles.
    always @(posedge clk) lhist <= {lhist[14:0], launch};

    always @(posedge launch) begin
        cur_delay = run_delay[run_idx % RUNS];
        run_idx++;
        rises++;
    end

    assign chain_in = (mode == M_STUCK0) ? 1'b0 :
                      (mode == M_STUCK1) ? 1'b1 :
                      (cur_delay == 0)   ? launch : lhist[cur_delay-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_meas(input string tag, input int m, input int d[RUNS],
                            input int e_res, input int e_runs, input int e_to,
                            input int e_rises, input int e_min, input int e_max);
        mode = m;
        run_delay = d;
        repeat (12) @(negedge clk);
        run_idx = 0;
        rises = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_after_start"}, busy, 1);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 15 && busy) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (done) break;
        end
        chk({tag, " done"}, done, 1);
        chk({tag, " busy_at_done"}, busy, 0);
        chk({tag, " launch_at_done"}, launch, 0);
        chk({tag, " result"}, result, e_res);
        chk({tag, " runs_done"}, runs_done, e_runs);
        chk({tag, " timeout"}, timeout, e_to);
        chk({tag, " launch_rises"}, rises, e_rises);
`ifdef ADDER_TIMER_MINMAX_EN
        chk({tag, " min_cycles"}, min_cycles, e_min);
        chk({tag, " max_cycles"}, max_cycles, e_max);
`endif
    endtask

    initial begin
        int d[RUNS];
        int sum, mn, mx;
        bit seen;

        vecs[0] = '{M_DELAY,  0, 0, 2, 8, 0, 8, 2, 2};
        vecs[1] = '{M_DELAY,  5, 5, 7, 8, 0, 8, 7, 7};
        vecs[2] = '{M_DELAY,  3, 5, 6, 8, 0, 8, 5, 7};
        vecs[3] = '{M_STUCK0, 0, 0, 0, 0, 1, 1, 'hffff, 0};
        vecs[4] = '{M_STUCK1, 0, 0, 0, 0, 1, 0, 'hffff, 0};
        vecs[5] = '{M_DELAY,  2, 2, 4, 8, 0, 8, 4, 4};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset launch", launch, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset timeout", timeout, 0);
        chk("reset result", result, 0);
        chk("reset runs_done", runs_done, 0);
        rst_n = 1'b1;
        active = 1'b1;

        for (int v = 0; v < 6; v++) begin
            for (int r = 0; r < RUNS; r++) d[r] = (r % 2 == 0) ? vecs[v].da : vecs[v].db;
            run_meas($sformatf("vec%0d", v), vecs[v].mode, d, vecs[v].e_res, vecs[v].e_runs,
                     vecs[v].e_to, vecs[v].e_rises, vecs[v].e_min, vecs[v].e_max);
        end

        // Random per-run delays; expected average from plain arithmetic over the runs.
        for (int k = 0; k < 3; k++) begin
            sum = 0;
            mn = 'hffff;
            mx = 0;
            for (int r = 0; r < RUNS; r++) begin
                d[r] = int'($urandom_range(0, 4));
                sum += 2 + d[r];
                if (2 + d[r] < mn) mn = 2 + d[r];
                if (2 + d[r] > mx) mx = 2 + d[r];
            end
            run_meas($sformatf("rand%0d", k), M_DELAY, d, sum / RUNS, 8, 0, 8, mn, mx);
        end

        // Drop active during the fourth run.
        mode = M_DELAY;
        run_delay = '{default: 2};
        repeat (12) @(negedge clk);
        run_idx = 0;
        rises = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (rises >= 4) break;
        end
        chk("abort rises", rises, 4);
        chk("abort runs_before", runs_done, 3);
        active = 1'b0;
        @(negedge clk);
        chk("abort busy", busy, 0);
        chk("abort launch", launch, 0);
        chk("abort done", done, 0);
        chk("abort runs_held", runs_done, 3);
        chk("abort result_held", result, 1);
        chk("abort timeout", timeout, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("inactive_start busy", busy, 0);
        chk("inactive_start runs", runs_done, 3);

        // Asynchronous reset while waiting for the chain.
        active = 1'b1;
        run_delay = '{default: 4};
        repeat (12) @(negedge clk);
        run_idx = 0;
        rises = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (launch) begin
                seen = 1'b1;
                break;
            end
        end
        chk("midwait launch_seen", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset launch", launch, 0);
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset timeout", timeout, 0);
        chk("midreset result", result, 0);
        chk("midreset runs_done", runs_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
